// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode -> execute pipeline register. Registers the execute opcode,
//   resolved operands and pass-through fields, and qualifies them with
//   aluEnable. Resolves read-after-write hazards (forwarding or stalling),
//   holds on a downstream stall, clears on flush, and counts stall cycles.
//
//   Build option: define ID_EX_FORWARD_EN to forward from EX/MEM and stall
//   only on load-use. Left undefined, no forwarding is done and any RAW
//   dependency on EX or MEM stalls until the writer has left MEM.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   idValid / idReady            decode handshake (idReady combinational)
//   idOp, idSrcl*/idSrcr*        opcode and source operands/indices
//   idDestReg, idWriteReg        destination and write flag
//   idIsLoad                     instruction is a load
//   flush                        kill registered and incoming instruction
//   memStall                     downstream hold
//   exResult                     ALU result of the instruction at the outputs
//   memWriteReg/DestReg/Result   MEM-stage writer
//   aluEnable, ex*               registered execute-stage outputs
//   stallCount                   cycles with idValid && !idReady
module id_ex_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  output logic                  idReady,
  input  logic [OP_W-1:0]       idOp,
  input  logic [31:0]           idSrclVal,
  input  logic [31:0]           idSrcrVal,
  input  logic [REG_ADDR_W-1:0] idSrclReg,
  input  logic [REG_ADDR_W-1:0] idSrcrReg,
  input  logic                  idSrclIsReg,
  input  logic                  idSrcrIsReg,
  input  logic [REG_ADDR_W-1:0] idDestReg,
  input  logic                  idWriteReg,
  input  logic                  idIsLoad,
  input  logic                  flush,
  input  logic                  memStall,
  input  logic [31:0]           exResult,
  input  logic                  memWriteReg,
  input  logic [REG_ADDR_W-1:0] memDestReg,
  input  logic [31:0]           memResult,
  output logic                  aluEnable,
  output logic [OP_W-1:0]       exOp,
  output logic [31:0]           exSrcl,
  output logic [31:0]           exSrcr,
  output logic [REG_ADDR_W-1:0] exDestReg,
  output logic                  exWriteReg,
  output logic                  exIsLoad,
  output logic [31:0]           stallCount
);

  logic        match_ex_l;
  logic        match_ex_r;
  logic        match_mem_l;
  logic        match_mem_r;
  logic        hazard;
  logic        accept;
  logic [31:0] srcl_sel;
  logic [31:0] srcr_sel;

  // Register 0 is hard-wired and never participates in a dependency.
  always_comb begin
    match_ex_l  = idSrclIsReg && exWriteReg && (exDestReg == idSrclReg) &&
                  (idSrclReg != '0);
    match_ex_r  = idSrcrIsReg && exWriteReg && (exDestReg == idSrcrReg) &&
                  (idSrcrReg != '0);
    match_mem_l = idSrclIsReg && memWriteReg && (memDestReg == idSrclReg) &&
                  (idSrclReg != '0);
    match_mem_r = idSrcrIsReg && memWriteReg && (memDestReg == idSrcrReg) &&
                  (idSrcrReg != '0);
`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot forward: its data is not available yet.
    hazard   = aluEnable && exIsLoad && (match_ex_l || match_ex_r);
    srcl_sel = match_ex_l ? exResult : (match_mem_l ? memResult : idSrclVal);
    srcr_sel = match_ex_r ? exResult : (match_mem_r ? memResult : idSrcrVal);
`else
    // Regfile is write-first, so once the writer leaves MEM the read is valid.
    hazard   = match_ex_l || match_ex_r || match_mem_l || match_mem_r;
    srcl_sel = idSrclVal;
    srcr_sel = idSrcrVal;
`endif
  end

`ifndef ID_EX_FORWARD_EN
  // Result buses are only needed when forwarding.
  logic unused_fwd_data;
  assign unused_fwd_data = ^{exResult, memResult};
`endif

  assign idReady = !rst && !flush && !memStall && !hazard;
  assign accept  = idValid && idReady;

  // accept already excludes flush/memStall/hazard; anything else that is not
  // a hold (memStall without flush) loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluEnable  <= 1'b0;
      exOp       <= '0;
      exSrcl     <= '0;
      exSrcr     <= '0;
      exDestReg  <= '0;
      exWriteReg <= 1'b0;
      exIsLoad   <= 1'b0;
      stallCount <= '0;
    end else begin
      if (idValid && !idReady) begin
        stallCount <= stallCount + 32'd1;
      end
      if (accept) begin
        aluEnable  <= 1'b1;
        exOp       <= idOp;
        exSrcl     <= srcl_sel;
        exSrcr     <= srcr_sel;
        exDestReg  <= idDestReg;
        exWriteReg <= idWriteReg;
        exIsLoad   <= idIsLoad;
      end else if (flush || !memStall) begin
        aluEnable  <= 1'b0;
        exOp       <= '0;
        exSrcl     <= '0;
        exSrcr     <= '0;
        exDestReg  <= '0;
        exWriteReg <= 1'b0;
        exIsLoad   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute that feeds the execute-stage ALUs (logic, arithmetic, shift) with a registered opcode, resolved operands and the `aluEnable` qualifier. It resolves read-after-write hazards by forwarding from EX and MEM, inserts a one-cycle bubble on load-use, holds on a downstream stall and kills its contents on a flush. It also keeps a stall-cycle counter for performance debug.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register index width
- `OP_W`, 8, execute opcode width, opaque to this block

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `idValid`  in  1  decode presents an instruction
- `idReady`  out  1  instruction accepted at this edge
- `idOp`  in  OP_W  execute opcode
- `idSrclVal`, `idSrcrVal`  in  32  regfile read value or immediate
- `idSrclReg`, `idSrcrReg`  in  5  source register indices
- `idSrclIsReg`, `idSrcrIsReg`  in  1  operand comes from a register (forwarding candidate)
- `idDestReg`  in  5  destination index
- `idWriteReg`  in  1  instruction writes a register
- `idIsLoad`  in  1  instruction is a load
- `flush`  in  1  kill ID/EX contents and the incoming instruction
- `memStall`  in  1  downstream cannot advance; hold
- `exResult`  in  32  ALU result of the instruction currently at this block's outputs
- `memWriteReg`  in  1, `memDestReg`  in  5, `memResult`  in  32  MEM-stage writer, with loaded data already resolved
- `aluEnable`  out  1  valid instruction in EX
- `exOp`  out  OP_W
- `exSrcl`, `exSrcr`  out  32
- `exDestReg`  out  5, `exWriteReg`  out  1, `exIsLoad`  out  1
- `stallCount`  out  32  cycles in which `idValid && !idReady`

## Operation
- Next-state priority: `rst` > `flush` > `memStall` (hold) > hazard (bubble) > accept.
- Reset and flush clear every output register to 0 (`aluEnable=0`, `exOp=0`, operands 0, `exDestReg=0`, `exWriteReg=0`, `exIsLoad=0`). Reset also clears `stallCount`; flush does not.
- On hold, all output registers keep their values.
- Bubble: output registers load all-zero (`aluEnable=0`), as on flush.
- Accept: `idValid && !flush && !memStall && !hazard` loads `aluEnable=1`, the resolved operands and the pass-through fields. If `idValid=0`, a bubble is loaded.
- `idReady = !rst && !flush && !memStall && !hazard`. The signal is combinational.
- Match(src, X) requires `src IsReg`, `XWriteReg`, `XDestReg == src Reg`, and `src Reg != 0`. Register 0 never matches.
- Forwarding priority is EX (`exResult`, using the current `exDestReg`/`exWriteReg`), then MEM (`memResult`), then `id*Val`.
- Load-use hazard: Match(any source, EX) while `exIsLoad=1` and `aluEnable=1`.
- `stallCount` increments by 1, wrapping at 2^32, on each edge where `idValid && !idReady && !rst`.

## Timing
- Latency is 1 cycle. An instruction accepted at edge t appears on the outputs after edge t.
- A load followed immediately by a dependent instruction costs exactly one bubble cycle. The dependent instruction then forwards from MEM.
- Simultaneous `flush` and `memStall`: flush wins and the outputs clear.
- Reset asserted mid-stall clears everything at the next edge. `idReady=0` while `rst=1`.
- Operand selection is evaluated in the accept cycle only. Held contents are never re-forwarded.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding and the load-use bubble behave as described above.
- `ID_EX_FORWARD_EN` undefined:
  - No forwarding; operands are always `id*Val`.
  - Hazard is Match(any source, EX) or Match(any source, MEM), which stalls until the writer leaves MEM.
  - The regfile is write-first, so WB needs no check.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `idValid=1` -> all outputs 0, `idReady=0`, `stallCount=0`.
- EX forward:
  - Accept `$3 = ...` (`idWriteReg=1`, `idDestReg=3`), `exResult=0x0000_00FF`.
  - Next, accept an instruction with `idSrclReg=3`, `idSrclVal=0x1234`.
  - Required: `exSrcl=0x0000_00FF`.
  - Without the macro: 2 stall cycles, then `exSrcl=idSrclVal`.
- Load-use:
  - Load to `$5`, then an instruction reading `$5`.
  - Required: one cycle with `idReady=0` and `aluEnable=0`, then accept with `exSrcr=memResult` (e.g. `0xDEAD_BEEF`); `stallCount=1`.
- `$0`: source and destination both register 0 with a writer in EX -> no forward, no stall, operand = `idSrclVal`.
- `memStall`: 3 cycles with a valid instruction held -> outputs unchanged, `idReady=0`, `stallCount` +3. The instruction is accepted on the first cycle after release.
- Flush during `memStall`: outputs zero next cycle, `stallCount` unchanged by the flush.
